// File: rtl/branch_pc_unit_if.sv
// branch_pc_unit_if: groups the control, compare, branch and LUT-write
// inputs and the fetch-address/status outputs of branch_pc_unit.
// master = instruction sequencer side, slave = branch_pc_unit itself.
interface branch_pc_unit_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic            stall;
  logic            halt;
  logic            cmp_we;
  logic [7:0]      cmp_rslt;
  logic            br_en;
  logic [1:0]      br_cond;
  logic [4:0]      br_idx;
  logic            lut_we;
  logic [4:0]      lut_addr;
  logic [PC_W-1:0] lut_data;
  logic [PC_W-1:0] prog_ctr;
  logic [1:0]      flags;
  logic            taken;
  logic            running;
  logic            done;

  modport master (
    output start, stall, halt, cmp_we, cmp_rslt,
    output br_en, br_cond, br_idx,
    output lut_we, lut_addr, lut_data,
    input  prog_ctr, flags, taken, running, done
  );

  modport slave (
    input  start, stall, halt, cmp_we, cmp_rslt,
    input  br_en, br_cond, br_idx,
    input  lut_we, lut_addr, lut_data,
    output prog_ctr, flags, taken, running, done
  );
endinterface

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: program-flow controller. Latches the ALU compare flags
// {ne, gt}, decodes branch conditions against them, and steps the fetch
// address. Jump targets come from a writable 32-entry LUT.
// Build option: define BR_RELATIVE_EN to treat LUT entries as signed
// PC-relative offsets instead of absolute target addresses.
module branch_pc_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  branch_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [1:0]      flags_reg;
  logic            taken_reg;
  logic            running_reg;
  logic            done_reg;

  // Target LUT; cleared by reset, so it is built from flops, not block RAM.
  logic [PC_W-1:0] lut_mem [32];

  logic            cond_true;
  logic [PC_W-1:0] lut_rd;
  logic [PC_W-1:0] br_target;
  logic            unused_cmp_bits;

  // Only the two compare bits of the ALU result bus carry information.
  assign unused_cmp_bits = ^bus.cmp_rslt[7:2];

  // LUT write port: accepted in any FSM state and regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        lut_mem[i] <= '0;
      end
    end else if (bus.lut_we) begin
      lut_mem[bus.lut_addr] <= bus.lut_data;
    end
  end

  // Combinational read: a same-cycle write to this index lands after the
  // edge, so the branch sees the previous entry.
  assign lut_rd = lut_mem[bus.br_idx];

`ifdef BR_RELATIVE_EN
  // Entry is a signed offset; wrap-around addition gives PC + offset mod 2^PC_W.
  assign br_target = pc_reg + lut_rd;
`else
  assign br_target = lut_rd;
`endif

  // Condition decode against the registered flags only (bitwise, no special
  // case for the unused 01 encoding).
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.br_cond)
      2'b00: cond_true = 1'b1;
      2'b01: cond_true = ~flags_reg[1];
      2'b10: cond_true = flags_reg[1];
      2'b11: cond_true = flags_reg[0];
      default: cond_true = 1'b0;
    endcase
  end

  // Program-flow FSM with registered PC, flags and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_reg      <= START_ADDR;
      flags_reg   <= 2'b00;
      taken_reg   <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          pc_reg    <= START_ADDR;
          taken_reg <= 1'b0;
          if (bus.start) begin
            state_reg   <= RUN;
            flags_reg   <= 2'b00;
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
          end
        end

        RUN: begin
          // Stall freezes everything in RUN, including flag capture.
          if (!bus.stall) begin
            if (bus.cmp_we) begin
              flags_reg <= bus.cmp_rslt[1:0];
            end
            if (bus.halt) begin
              state_reg   <= DONE;
              taken_reg   <= 1'b0;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end else if (bus.br_en && cond_true) begin
              pc_reg    <= br_target;
              taken_reg <= 1'b1;
            end else begin
              pc_reg    <= pc_reg + 1'b1;
              taken_reg <= 1'b0;
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            state_reg   <= RUN;
            pc_reg      <= START_ADDR;
            flags_reg   <= 2'b00;
            taken_reg   <= 1'b0;
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
          end
        end

        default: begin
          state_reg   <= IDLE;
          pc_reg      <= START_ADDR;
          flags_reg   <= 2'b00;
          taken_reg   <= 1'b0;
          running_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_ctr = pc_reg;
  assign bus.flags    = flags_reg;
  assign bus.taken    = taken_reg;
  assign bus.running  = running_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed-vector bench for branch_pc_unit with
// hand-derived expected PC, flags and status values.
module tb_branch_pc_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [9:0] p;

  branch_pc_unit_if #(.PC_W(10)) bus ();

  branch_pc_unit #(
    .PC_W       (10),
    .START_ADDR (10'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected taken-branch target for the active build.
  function automatic logic [9:0] tgt(input logic [9:0] pc, input logic [9:0] v);
`ifdef BR_RELATIVE_EN
    return pc + v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 0; bus.stall = 0; bus.halt = 0; bus.cmp_we = 0; bus.cmp_rslt = 8'h00;
    bus.br_en = 0; bus.br_cond = 2'b00; bus.br_idx = 5'd0;
    bus.lut_we = 0; bus.lut_addr = 5'd0; bus.lut_data = 10'h000;

    // Reset state
    step(); step();
    chk("rst_pc", bus.prog_ctr, 10'h000);
    chk("rst_flags", bus.flags, 2'b00);
    chk("rst_taken", bus.taken, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_running", bus.running, 1'b0);

    // Start and sequential stepping 0..5
    bus.start = 1; step(); bus.start = 0;
    p = 10'h000;
    chk("start_running", bus.running, 1'b1);
    chk("start_pc", bus.prog_ctr, p);
    chk("start_flags", bus.flags, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      step(); p = p + 1'b1;
      chk("seq_pc", bus.prog_ctr, p);
    end

    // LUT[3]=0x120 and flags=11 (upper result bits ignored)
    bus.lut_we = 1; bus.lut_addr = 5'd3; bus.lut_data = 10'h120;
    bus.cmp_we = 1; bus.cmp_rslt = 8'hF3;
    step(); p = p + 1'b1;
    bus.lut_we = 0; bus.cmp_we = 0;
    chk("cmp_pc", bus.prog_ctr, p);
    chk("cmp_flags", bus.flags, 2'b11);
    bus.br_en = 1; bus.br_cond = 2'b11; bus.br_idx = 5'd3;
    step(); p = tgt(p, 10'h120);
    chk("br_gt_pc", bus.prog_ctr, p);
    chk("br_gt_taken", bus.taken, 1'b1);
    bus.br_cond = 2'b01;
    step(); p = p + 1'b1;
    chk("br_eq_nt_pc", bus.prog_ctr, p);
    chk("br_eq_nt_taken", bus.taken, 1'b0);

    // Flags=10, not-equal taken
    bus.br_en = 0; bus.cmp_we = 1; bus.cmp_rslt = 8'h02;
    step(); p = p + 1'b1;
    chk("flags_ne", bus.flags, 2'b10);
    bus.cmp_we = 0; bus.br_en = 1; bus.br_cond = 2'b10; bus.br_idx = 5'd3;
    step(); p = tgt(p, 10'h120);
    chk("br_ne_pc", bus.prog_ctr, p);
    chk("br_ne_taken", bus.taken, 1'b1);

    // CmpWe and BrEn together: branch sees old flags
    bus.cmp_we = 1; bus.cmp_rslt = 8'h00; bus.br_cond = 2'b01;
    step(); p = p + 1'b1;
    chk("old_flags_pc", bus.prog_ctr, p);
    chk("old_flags_taken", bus.taken, 1'b0);
    chk("new_flags", bus.flags, 2'b00);
    bus.cmp_we = 0;
    step(); p = tgt(p, 10'h120);
    chk("br_eq_pc", bus.prog_ctr, p);
    chk("br_eq_taken", bus.taken, 1'b1);

    // Stall for 3 cycles with branch, compare and LUT write pending
    bus.stall = 1; bus.br_cond = 2'b00; bus.br_idx = 5'd3;
    bus.cmp_we = 1; bus.cmp_rslt = 8'h02;
    bus.lut_we = 1; bus.lut_addr = 5'd5; bus.lut_data = 10'h0AB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.prog_ctr, p);
      chk("stall_flags", bus.flags, 2'b00);
      chk("stall_taken", bus.taken, 1'b1);
    end
    bus.stall = 0; bus.lut_we = 0;
    step(); p = tgt(p, 10'h120);
    chk("unstall_pc", bus.prog_ctr, p);
    chk("unstall_flags", bus.flags, 2'b10);
    bus.cmp_we = 0; bus.br_idx = 5'd5;
    step(); p = tgt(p, 10'h0AB);
    chk("stall_lutwr_pc", bus.prog_ctr, p);

    // Same-cycle LUT write and branch read: old entry used
    bus.lut_we = 1; bus.lut_addr = 5'd3; bus.lut_data = 10'h200; bus.br_idx = 5'd3;
    step(); p = tgt(p, 10'h120);
    chk("wr_rd_old_pc", bus.prog_ctr, p);
    bus.lut_we = 0;
    step(); p = tgt(p, 10'h200);
    chk("wr_rd_new_pc", bus.prog_ctr, p);

    // Branch to 0x3FE, then wrap through 0x3FF to 0x000
    bus.br_en = 0; bus.stall = 1; bus.lut_we = 1; bus.lut_addr = 5'd7;
`ifdef BR_RELATIVE_EN
    bus.lut_data = 10'h3FE - p;
`else
    bus.lut_data = 10'h3FE;
`endif
    step();
    bus.stall = 0; bus.lut_we = 0; bus.br_en = 1; bus.br_cond = 2'b00; bus.br_idx = 5'd7;
    step();
    chk("wrap_tgt", bus.prog_ctr, 10'h3FE);
    bus.br_en = 0;
    step(); chk("wrap_3ff", bus.prog_ctr, 10'h3FF);
    step(); chk("wrap_000", bus.prog_ctr, 10'h000);
    step(); chk("wrap_001", bus.prog_ctr, 10'h001);

    // Halt wins over branch
    bus.halt = 1; bus.br_en = 1; bus.br_idx = 5'd3;
    step();
    chk("halt_pc", bus.prog_ctr, 10'h001);
    chk("halt_done", bus.done, 1'b1);
    chk("halt_running", bus.running, 1'b0);
    chk("halt_taken", bus.taken, 1'b0);
    bus.halt = 0; bus.br_en = 0; bus.cmp_we = 1; bus.cmp_rslt = 8'h03;
    step();
    chk("done_pc", bus.prog_ctr, 10'h001);
    chk("done_flags", bus.flags, 2'b10);
    bus.cmp_we = 0; bus.start = 1;
    step(); bus.start = 0;
    chk("restart_pc", bus.prog_ctr, 10'h000);
    chk("restart_running", bus.running, 1'b1);
    chk("restart_done", bus.done, 1'b0);
    chk("restart_flags", bus.flags, 2'b00);

    // Start while running is ignored
    bus.start = 1; step(); bus.start = 0;
    chk("start_in_run_pc", bus.prog_ctr, 10'h001);

    // Flags=01 decoded bitwise: greater true, equal true
    bus.cmp_we = 1; bus.cmp_rslt = 8'h01;
    step(); p = 10'h002;
    chk("flags_01", bus.flags, 2'b01);
    bus.cmp_we = 0; bus.br_en = 1; bus.br_cond = 2'b11; bus.br_idx = 5'd5;
    step(); p = tgt(p, 10'h0AB);
    chk("f01_gt_pc", bus.prog_ctr, p);
    bus.br_cond = 2'b01; bus.br_idx = 5'd3;
    step(); p = tgt(p, 10'h200);
    chk("f01_eq_pc", bus.prog_ctr, p);
    chk("f01_eq_taken", bus.taken, 1'b1);

    // Asynchronous reset mid-stall
    bus.stall = 1;
    step();
    #2; rst = 1; #1;
    chk("async_rst_pc", bus.prog_ctr, 10'h000);
    chk("async_rst_running", bus.running, 1'b0);
    chk("async_rst_flags", bus.flags, 2'b00);
    chk("async_rst_taken", bus.taken, 1'b0);
    @(posedge clk); #1;
    rst = 0; bus.stall = 0; bus.br_en = 0; bus.start = 1;
    step(); bus.start = 0;
    chk("post_rst_running", bus.running, 1'b1);
    step();
    bus.br_en = 1; bus.br_cond = 2'b00; bus.br_idx = 5'd3;
    step(); p = tgt(10'h001, 10'h000);
    chk("lut_cleared_pc", bus.prog_ctr, p);
    bus.br_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Sequential program-flow controller that consumes the ALU compare encoding and produces the instruction fetch address.
- Latches the 2-bit compare result (bit1 = not-equal, bit0 = greater-than) from the ALU result bus into a flag register.
- Decodes branch conditions against those flags and steps the program counter.
- Jumps use a 5-bit index into a writable 32-entry target LUT. The unit sits between the ALU writeback path and instruction memory.

Parameters:
- PC_W, 10, program counter width in bits.
- START_ADDR, 0, PC value loaded on reset and on Start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin or restart program execution.
- Stall  input  1  freeze PC, flags and FSM for this cycle.
- Halt  input  1  current instruction is halt.
- CmpWe  input  1  latch compare flags this cycle.
- CmpRslt  input  8  ALU result bus; only bits [1:0] are used.
- BrEn  input  1  current instruction is a branch.
- BrCond  input  2  condition: 00 always, 01 equal, 10 not-equal, 11 greater.
- BrIdx  input  5  target LUT index.
- LutWe  input  1  write a LUT entry.
- LutAddr  input  5  LUT write index.
- LutData  input  PC_W  LUT write data.
- ProgCtr  output  PC_W  current fetch address.
- Flags  output  2  registered compare flags {ne, gt}.
- Taken  output  1  registered: the previous PC update was a taken branch.
- Running  output  1  FSM in RUN.
- Done  output  1  FSM in DONE.

Behaviour:
- Reset (async, any state):
  - FSM to IDLE.
  - ProgCtr = START_ADDR; Flags = 00; Taken = 0; Running = 0; Done = 0.
  - All LUT entries = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ProgCtr held at START_ADDR. Start=1 moves to RUN next edge, with PC = START_ADDR and Flags = 00.
  - RUN: Running=1. On each edge with Stall=0, the following apply in priority order:
    - Halt=1 -> DONE; PC holds the halt address.
    - BrEn=1 and condition true -> PC = LUT[BrIdx]; Taken=1 next cycle.
    - Otherwise -> PC = PC+1 modulo 2^PC_W (all-ones wraps to 0); Taken=0.
  - RUN with Stall=1: PC, Flags, Taken and state all hold. Stall has priority over Halt, BrEn and CmpWe.
  - DONE: Done=1, PC held. Start=1 -> RUN with PC = START_ADDR and Flags = 00. Other inputs are ignored.
- Start while in RUN is ignored.
- Condition decode uses the registered Flags only:
  - equal = ~Flags[1]
  - not-equal = Flags[1]
  - greater = Flags[0]
  - always = 1
  - Flags = 01 is not produced by the ALU, but it is decoded bitwise with no special case.
- Flags capture: in RUN with Stall=0 and CmpWe=1, Flags <= CmpRslt[1:0] at the edge. CmpWe is ignored outside RUN.
- CmpWe and BrEn in the same cycle: the branch evaluates the old Flags; the new Flags are visible from the next cycle.
- Halt and BrEn in the same cycle: Halt wins; no branch, Taken=0.
- LUT behaviour:
  - Writes are accepted in any state, including during Stall.
  - Reads are combinational.
  - A write and a branch read to the same index in the same cycle: the branch uses the old entry.
- Reset asserted mid-RUN or mid-Stall: immediate return to reset values; LUT cleared.
- Latency:
  - PC change is visible one cycle after the branch instruction is presented.
  - Taken is asserted in the same cycle as the new PC and lasts one cycle unless branches are back-to-back.

Optional Feature:
- Macro: BR_RELATIVE_EN.
- When defined, a LUT entry is a signed two's-complement PC offset: taken target = PC + LUT[BrIdx], computed modulo 2^PC_W.
- When undefined, a LUT entry is an absolute target address.
- Only the target computation changes between the two builds. FSM, flags and priorities are identical.

Test Plan:
- Reset, then Start, then 5 clean cycles -> ProgCtr 0,1,2,3,4,5; Running=1; Flags=00.
- Write LUT[3]=0x120; CmpWe with CmpRslt=0x03; next cycle BrEn, BrCond=11, BrIdx=3 -> ProgCtr=0x120, Taken=1. With the same stimulus but BrCond=01 -> PC+1, Taken=0.
- CmpWe with CmpRslt=0x00 and BrEn, BrCond=01 in the same cycle, with prior Flags=10 -> branch not taken (old flags); Flags=00 the next cycle.
- Stall held 3 cycles while BrEn=1 and CmpWe=1 -> PC, Flags and Taken unchanged. Releasing Stall -> the branch resolves.
- PC at 0x3FF with no branch -> wraps to 0x000. Halt=1 -> Done=1, PC frozen. Start -> PC=0, Running=1.
- BR_RELATIVE_EN build: PC=0x010, LUT[1]=0x3FC (-4), BrCond=00 -> PC=0x00C. Assert Reset mid-run -> PC=0, FSM in IDLE, LUT[1]=0.
